// File: rtl/ace_pkg.sv
// Shared types and encodings for the ACE cache-line bus controller.
package ace_pkg;

  // Controller FSM states
  typedef enum logic [2:0] {
    IDLE,
    AR_SEND,
    R_WAIT,
    AW_W_SEND,
    B_WAIT,
    DONE
  } state_t;

  // Operation captured from the cache controller
  typedef enum logic [1:0] {
    READ,
    CLEAN,
    WRITE
  } op_t;

  // Snoop encodings driven on AR/AW
  localparam logic [3:0] SNOOP_READ_SHARED  = 4'b0001;
  localparam logic [3:0] SNOOP_CLEAN_UNIQUE = 4'b1011;
  localparam logic [2:0] SNOOP_WRITE_BACK   = 3'b011;

  // Response codes on R/B
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // True for slave or decode error responses
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/ace_watchdog.sv
// Per-state cycle counter; flags expiry after TIMEOUT_CYCLES cycles in one wait state.
module ace_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_active,
  input  logic i_clear,
  output logic o_expired_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_expired_c = i_active && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count cycles spent in the current wait state; restart on any state change
  always_ff @(posedge clk) begin
    if (reset || i_clear || !i_active) begin
      r_cnt <= '0;
    end else if (!o_expired_c) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ace_controller.sv
// ACE single-beat line controller: ReadShared / CleanUnique / WriteBack.
// Optional watchdog enabled by defining ACE_TIMEOUT_EN.
module ace_controller
  import ace_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned LINE_WIDTH     = 128,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read_req,
  input  logic                  write_req,
  input  logic                  invalid_req,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LINE_WIDTH-1:0] wb_data,
  output logic                  ace_ready,
  output logic [LINE_WIDTH-1:0] fill_data,
  output logic                  fill_shared,
  output logic                  fill_dirty,
  output logic                  bus_error,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [3:0]            arsnoop,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [LINE_WIDTH-1:0] rdata,
  input  logic [3:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [2:0]            awsnoop,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [LINE_WIDTH-1:0] wdata,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  state_t                r_state;
  state_t                w_state_nxt;
  op_t                   r_op;
  op_t                   w_op_nxt;
  logic                  w_capture;
  logic                  w_timeout;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LINE_WIDTH-1:0] r_wdata;
  logic                  r_aw_done;
  logic                  r_w_done;
  logic                  r_err;
  logic [LINE_WIDTH-1:0] r_fill_data;
  logic                  r_fill_shared;
  logic                  r_fill_dirty;

`ifdef ACE_TIMEOUT_EN
  logic w_wd_active;
  logic w_wd_clear;

  assign w_wd_active = (r_state != IDLE) && (r_state != DONE);
  assign w_wd_clear  = (w_state_nxt != r_state);

  ace_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk        (clk),
    .reset      (reset),
    .i_active   (w_wd_active),
    .i_clear    (w_wd_clear),
    .o_expired_c(w_timeout)
  );
`else
  logic w_unused_timeout;

  assign w_timeout        = 1'b0;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, request arbitration (write > invalidate > read)
  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (write_req) begin
          w_capture   = 1'b1;
          w_op_nxt    = WRITE;
          w_state_nxt = AW_W_SEND;
        end else if (invalid_req) begin
          w_capture   = 1'b1;
          w_op_nxt    = CLEAN;
          w_state_nxt = AR_SEND;
        end else if (read_req) begin
          w_capture   = 1'b1;
          w_op_nxt    = READ;
          w_state_nxt = AR_SEND;
        end
      end
      AR_SEND:   if (arready) w_state_nxt = R_WAIT;
      R_WAIT:    if (rvalid) w_state_nxt = DONE;
      AW_W_SEND: if (r_aw_done && r_w_done) w_state_nxt = B_WAIT;
      B_WAIT:    if (bvalid) w_state_nxt = DONE;
      DONE:      w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
    if (w_timeout) begin
      w_state_nxt = DONE;
    end
  end

  // Request latch, handshake flags and response capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op          <= READ;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_aw_done     <= 1'b0;
      r_w_done      <= 1'b0;
      r_err         <= 1'b0;
      r_fill_data   <= '0;
      r_fill_shared <= 1'b0;
      r_fill_dirty  <= 1'b0;
    end else begin
      if (w_capture) begin
        r_op      <= w_op_nxt;
        r_addr    <= req_addr;
        r_wdata   <= wb_data;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        r_err     <= 1'b0;
      end
      if (awvalid && awready) begin
        r_aw_done <= 1'b1;
      end
      if (wvalid && wready) begin
        r_w_done <= 1'b1;
      end
      if ((r_state == R_WAIT) && rvalid) begin
        r_fill_shared <= rresp[3];
        r_fill_dirty  <= rresp[2];
        r_err         <= resp_is_err(rresp[1:0]);
        if (r_op == READ) begin
          r_fill_data <= rdata;
        end
      end
      if ((r_state == B_WAIT) && bvalid) begin
        r_err <= resp_is_err(bresp);
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  // Bus and completion outputs decoded from registered state and flags
  assign arvalid     = (r_state == AR_SEND);
  assign araddr      = r_addr;
  assign arsnoop     = arvalid ? ((r_op == CLEAN) ? SNOOP_CLEAN_UNIQUE : SNOOP_READ_SHARED)
                               : 4'b0000;
  assign rready      = (r_state == R_WAIT);
  assign awvalid     = (r_state == AW_W_SEND) && !r_aw_done;
  assign awaddr      = r_addr;
  assign awsnoop     = (r_state == AW_W_SEND) ? SNOOP_WRITE_BACK : 3'b000;
  assign wvalid      = (r_state == AW_W_SEND) && !r_w_done;
  assign wdata       = r_wdata;
  assign wlast       = 1'b1;
  assign bready      = (r_state == B_WAIT);
  assign ace_ready   = (r_state == DONE);
  assign bus_error   = (r_state == DONE) && r_err;
  assign fill_data   = r_fill_data;
  assign fill_shared = r_fill_shared;
  assign fill_dirty  = r_fill_dirty;

endmodule

// File: tb/tb_ace_controller.sv
// Directed scoreboard bench for ace_controller.
module tb_ace_controller;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 128;
  localparam logic [LW-1:0] D_A5 = {16{8'hA5}};
  localparam logic [LW-1:0] D_5A = {16{8'h5A}};
  localparam logic [LW-1:0] D_FF = {16{8'hFF}};
  localparam logic [LW-1:0] D_12 = {8{16'h1234}};
  localparam logic [LW-1:0] D_0F = {16{8'h0F}};

  typedef struct {
    logic [AW-1:0] addr;
    logic [3:0]    snoop;
  } ar_exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
  } aw_exp_t;

  typedef struct {
    logic [LW-1:0] data;
    logic          shared;
    logic          dirty;
    logic          err;
    logic          chk_flags;
  } cpl_exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          read_req, write_req, invalid_req;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] wb_data;
  logic          ace_ready;
  logic [LW-1:0] fill_data;
  logic          fill_shared, fill_dirty, bus_error;
  logic [AW-1:0] araddr;
  logic [3:0]    arsnoop;
  logic          arvalid, arready;
  logic [LW-1:0] rdata;
  logic [3:0]    rresp;
  logic          rvalid, rready;
  logic [AW-1:0] awaddr;
  logic [2:0]    awsnoop;
  logic          awvalid, awready;
  logic [LW-1:0] wdata;
  logic          wlast, wvalid, wready;
  logic [1:0]    bresp;
  logic          bvalid, bready;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  ar_exp_t  ar_q[$];
  aw_exp_t  aw_q[$];
  cpl_exp_t cpl_q[$];

  ace_controller dut (
    .clk(clk), .reset(reset),
    .read_req(read_req), .write_req(write_req), .invalid_req(invalid_req),
    .req_addr(req_addr), .wb_data(wb_data),
    .ace_ready(ace_ready), .fill_data(fill_data),
    .fill_shared(fill_shared), .fill_dirty(fill_dirty), .bus_error(bus_error),
    .araddr(araddr), .arsnoop(arsnoop), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsnoop(awsnoop), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic miss(input string nm);
    total = total + 1;
    bad   = bad + 1;
    $display("FAIL %s: got unexpected transfer expected none", nm);
  endtask

  // Monitor: pops expectations whenever the DUT presents a transfer or completion
  always @(negedge clk) begin
    ar_exp_t  ae;
    aw_exp_t  we;
    cpl_exp_t ce;
    if (!reset) begin
      if (arvalid && arready) begin
        if (ar_q.size() == 0) miss("ar_unexpected");
        else begin
          ae = ar_q.pop_front();
          chk("araddr", LW'(araddr), LW'(ae.addr));
          chk("arsnoop", LW'(arsnoop), LW'(ae.snoop));
        end
      end
      if (awvalid && awready) begin
        if (aw_q.size() == 0) miss("aw_unexpected");
        else begin
          we = aw_q[0];
          chk("awaddr", LW'(awaddr), LW'(we.addr));
          chk("awsnoop", LW'(awsnoop), LW'(3'b011));
        end
      end
      if (wvalid && wready) begin
        if (aw_q.size() == 0) miss("w_unexpected");
        else begin
          chk("wdata", wdata, aw_q[0].data);
          chk("wlast", LW'(wlast), LW'(1'b1));
        end
      end
      if (bvalid && bready && aw_q.size() != 0) void'(aw_q.pop_front());
      if (ace_ready) begin
        if (cpl_q.size() == 0) miss("cpl_unexpected");
        else begin
          ce = cpl_q.pop_front();
          chk("fill_data", fill_data, ce.data);
          chk("bus_error", LW'(bus_error), LW'(ce.err));
          if (ce.chk_flags) begin
            chk("fill_shared", LW'(fill_shared), LW'(ce.shared));
            chk("fill_dirty", LW'(fill_dirty), LW'(ce.dirty));
          end
        end
      end
    end
  end

  task automatic check_zero(input string nm);
    chk({nm, "_ace_ready"}, LW'(ace_ready), '0);
    chk({nm, "_fill_data"}, fill_data, '0);
    chk({nm, "_flags"}, LW'({fill_shared, fill_dirty, bus_error}), '0);
    chk({nm, "_valids"}, LW'({arvalid, awvalid, wvalid}), '0);
    chk({nm, "_readies"}, LW'({rready, bready}), '0);
    chk({nm, "_addrs"}, LW'({araddr, awaddr}), '0);
    chk({nm, "_snoops"}, LW'({arsnoop, awsnoop}), '0);
    chk({nm, "_wdata"}, wdata, '0);
  endtask

  // Bounded wait for ace_ready; optional latency check from request cycle t0
  task automatic wait_done(input string nm, input int t0, input int exp_lat);
    int  n    = 0;
    bit  seen = 1'b0;
    while (!seen && n < 400) begin
      @(negedge clk);
      n = n + 1;
      if (ace_ready) seen = 1'b1;
    end
    chk({nm, "_done"}, LW'(seen), LW'(1'b1));
    if (seen && exp_lat >= 0) chk({nm, "_latency"}, LW'(cyc - t0), LW'(exp_lat));
  endtask

  task automatic clear_slave();
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int t0;
    reset = 1'b1; read_req = 1'b0; write_req = 1'b0; invalid_req = 1'b0;
    req_addr = '0; wb_data = '0;
    clear_slave();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Read: ReadShared, shared response, minimum latency
    @(posedge clk); #1;
    read_req = 1'b1; req_addr = 32'h1000;
    arready = 1'b1; rvalid = 1'b1; rdata = D_A5; rresp = 4'b1000;
    ar_q.push_back('{addr: 32'h1000, snoop: 4'b0001});
    cpl_q.push_back('{data: D_A5, shared: 1'b1, dirty: 1'b0, err: 1'b0, chk_flags: 1'b1});
    t0 = cyc;
    @(posedge clk); #1;
    read_req = 1'b0;
    wait_done("read", t0, 3);
    clear_slave();

    // Write: wready first, awready two cycles later
    @(posedge clk); #1;
    write_req = 1'b1; req_addr = 32'h2000; wb_data = D_5A;
    wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
    aw_q.push_back('{addr: 32'h2000, data: D_5A});
    cpl_q.push_back('{data: D_A5, shared: 1'b0, dirty: 1'b0, err: 1'b0, chk_flags: 1'b0});
    t0 = cyc;
    @(posedge clk); #1;
    write_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    awready = 1'b1;
    wait_done("write", t0, 6);
    clear_slave();
    @(negedge clk);
    chk("write_single_ready", LW'(ace_ready), '0);

    // Invalidate: CleanUnique, fill_data must hold
    @(posedge clk); #1;
    invalid_req = 1'b1; req_addr = 32'h3000;
    arready = 1'b1; rvalid = 1'b1; rdata = D_FF; rresp = 4'b0100;
    ar_q.push_back('{addr: 32'h3000, snoop: 4'b1011});
    cpl_q.push_back('{data: D_A5, shared: 1'b0, dirty: 1'b1, err: 1'b0, chk_flags: 1'b1});
    t0 = cyc;
    @(posedge clk); #1;
    invalid_req = 1'b0;
    wait_done("clean", t0, 3);
    clear_slave();
    @(negedge clk);
    chk("clean_single_ready", LW'(ace_ready), '0);

    // Write and read together: write wins, read held through DONE starts afterwards
    @(posedge clk); #1;
    write_req = 1'b1; read_req = 1'b1; req_addr = 32'h4000; wb_data = D_12;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b10;
    arready = 1'b1; rvalid = 1'b1; rdata = D_0F; rresp = 4'b0011;
    aw_q.push_back('{addr: 32'h4000, data: D_12});
    cpl_q.push_back('{data: D_A5, shared: 1'b0, dirty: 1'b0, err: 1'b1, chk_flags: 1'b0});
    t0 = cyc;
    @(posedge clk); #1;
    write_req = 1'b0;
    wait_done("prio_write", t0, 4);
    chk("prio_no_ar_in_done", LW'(arvalid), '0);
    ar_q.push_back('{addr: 32'h4000, snoop: 4'b0001});
    cpl_q.push_back('{data: D_0F, shared: 1'b0, dirty: 1'b0, err: 1'b1, chk_flags: 1'b1});
    @(posedge clk); #1;
    t0 = cyc;
    @(negedge clk);
    chk("prio_idle_no_ar", LW'(arvalid), '0);
    @(posedge clk); #1;
    read_req = 1'b0;
    @(negedge clk);
    chk("prio_ar_after_done", LW'(arvalid), LW'(1'b1));
    wait_done("prio_read", t0, 3);
    clear_slave();

    // Reset while waiting for R
    @(posedge clk); #1;
    read_req = 1'b1; req_addr = 32'h5000; arready = 1'b1;
    ar_q.push_back('{addr: 32'h5000, snoop: 4'b0001});
    @(posedge clk); #1;
    read_req = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_r_wait", LW'(rready), LW'(1'b1));
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_zero("rst_mid");
    @(posedge clk); #1;
    reset = 1'b0; rvalid = 1'b1; rdata = D_FF;
    repeat (4) @(negedge clk);
    chk("rst_discarded", LW'(ace_ready), '0);
    clear_slave();

`ifdef ACE_TIMEOUT_EN
    // Watchdog: AR never accepted
    @(posedge clk); #1;
    read_req = 1'b1; req_addr = 32'h6000; arready = 1'b0;
    cpl_q.push_back('{data: '0, shared: 1'b0, dirty: 1'b0, err: 1'b1, chk_flags: 1'b1});
    t0 = cyc;
    @(posedge clk); #1;
    read_req = 1'b0;
    wait_done("timeout", t0, -1);
    clear_slave();
`endif

    repeat (2) @(posedge clk);
    chk("ar_queue_empty", LW'(ar_q.size()), '0);
    chk("aw_queue_empty", LW'(aw_q.size()), '0);
    chk("cpl_queue_empty", LW'(cpl_q.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
